ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Drives the head of a configuration-chain (ccff) shift register. The chain is built from the per-mux `_mem` blocks inside connection and switch blocks.
- Accepts bitstream words over a valid/ready interface, serializes them MSB-first onto `ccff_head`, and generates a per-bit shift enable that gates `prog_clk` to the chain.
- Counts exactly `CHAIN_LENGTH` bits, then signals completion.
- Captures the bits displaced out of `ccff_tail` as a readback word stream, so software can check the previous configuration.

Parameters:
- CHAIN_LENGTH, 4, number of config flops in the downstream chain (must be ≥1).
- WORD_WIDTH, 8, bits per input and readback word.
- CNT_WIDTH, 16, width of the chain bit counter (`2^CNT_WIDTH` > CHAIN_LENGTH).

Ports:
- prog_clk  input  1  programming clock; all logic on rising edge.
- prog_reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled in IDLE only.
- abort  input  1  cancel an active load.
- word_in  input  WORD_WIDTH  bitstream word, MSB shifted first.
- word_valid  input  1  `word_in` valid.
- word_ready  output  1  loader accepts `word_in` this cycle.
- ccff_head  output  1  serial config bit to the chain head.
- ccff_en  output  1  chain clock enable; the chain shifts on each `prog_clk` edge where `ccff_en`=1.
- ccff_tail  input  1  serial bit returned from the chain tail.
- tail_word  output  WORD_WIDTH  readback word, MSB = first displaced bit.
- tail_valid  output  1  one-cycle pulse, `tail_word` valid.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse after the final shift.
- aborted  output  1  one-cycle pulse on abort.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0.
  - bit counter, shift register and bits_left cleared.
  - Reset mid-load abandons the load; no `done` and no `aborted`.
- States: IDLE, LOAD, FIN.
- IDLE:
  - `start`=1 → LOAD next cycle; `bit_cnt`=0, `bits_left`=0.
  - `word_valid` is ignored and `word_ready`=0.
- LOAD, input side:
  - `word_ready` = (`bits_left`==0) AND (`bit_cnt` + pending < CHAIN_LENGTH). It is combinational from registered state only.
  - On a handshake (`word_valid` & `word_ready`): `shreg` ← `word_in`, `bits_left` ← WORD_WIDTH.
- LOAD, shift side:
  - Each cycle with `bits_left`>0 and `bit_cnt`<CHAIN_LENGTH, the registered outputs update next edge: `ccff_head` ← `shreg[MSB]`, `ccff_en` ← 1.
  - Same edge: `shreg` shifts left, `bits_left`−1, `bit_cnt`+1.
  - Otherwise `ccff_en` ← 0 and `ccff_head` holds its last value.
  - Word-to-first-bit latency: 1 cycle after the handshake. Back-to-back words sustain 1 bit per cycle except for one bubble cycle per word. That bubble is acceptable and must be exactly 1 cycle.
- Last word:
  - When `bit_cnt` reaches CHAIN_LENGTH mid-word, the remaining LSBs are discarded.
  - Words consumed = ceil(CHAIN_LENGTH/WORD_WIDTH).
- Readback:
  - On every edge where `ccff_en`=1, `ccff_tail` is shifted into `tail_sh` (LSB-in, MSB-first order).
  - After every WORD_WIDTH captured bits: `tail_word` ← `tail_sh`, `tail_valid` pulses.
  - A final partial group is left-aligned and zero-padded, and pulses `tail_valid` on the same cycle as `done`.
- LOAD → FIN when the edge with `ccff_en`=1 and `bit_cnt`==CHAIN_LENGTH has occurred.
- FIN: `done`=1 for one cycle, `ccff_en`=0, → IDLE.
- abort:
  - Any cycle in LOAD → IDLE next edge.
  - `ccff_en` ← 0 on that edge; `aborted` pulses; no `done`; a partial `tail_sh` is dropped.
  - `abort` has priority over a simultaneous handshake; the word is not consumed.
- `start` is ignored outside IDLE. `start` and `abort` together in IDLE → `start` wins (abort applies only in LOAD).
- `busy` = (state==LOAD).

Test Plan:
- Basic load: CHAIN_LENGTH=4, WORD_WIDTH=8, chain preloaded 0110, start, `word_in`=0xA5 → `ccff_head` = 1,0,1,0 with `ccff_en` high exactly 4 consecutive cycles, then `tail_word`=0x60 with `tail_valid` and `done` on the same cycle; only 1 word accepted.
- Multi-word: CHAIN_LENGTH=20, words 0xFF, 0x00, 0xC3 → 20 enables total, with exactly 1 bubble cycle between words. Chain ends holding 0xFF,0x00,0xC (LSB bits 0x3 of the last word discarded). `tail_valid` pulses 3 times; the last pulse is a zero-padded nibble.
- Stall: `word_valid` withheld 5 cycles mid-stream → `ccff_en`=0 during the stall, `ccff_head` held, `bit_cnt` unchanged, load completes correctly.
- Abort: assert `abort` after 2 bits of the CHAIN_LENGTH=4 load → `ccff_en` low next edge, `aborted`=1 for 1 cycle, `done` never asserted, `busy`=0.
- Reset mid-load: drop `prog_reset_n` asynchronously mid-word → all outputs 0 immediately, no `done`/`aborted`; a subsequent `start` performs a full clean load.
- Protocol edge cases: `word_valid` asserted in IDLE → `word_ready`=0, word not consumed. `start` pulsed during LOAD → no effect on the bit count.

Source files
------------

// File: rtl/ccff_bitstream_loader_if.sv
// Word stream interface of the ccff loader: bitstream words in, readback words out.
interface ccff_bitstream_loader_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  word_ready;
    logic [WORD_WIDTH-1:0] tail_word;
    logic                  tail_valid;

    modport master (
        output word_in, word_valid,
        input  word_ready, tail_word, tail_valid
    );

    modport slave (
        input  word_in, word_valid,
        output word_ready, tail_word, tail_valid
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words MSB-first into a ccff configuration chain,
// gates the chain clock per bit, and collects the displaced tail bits
// as readback words.
module ccff_bitstream_loader #(
    parameter int CHAIN_LENGTH = 4,
    parameter int WORD_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic prog_clk,
    input  logic prog_reset_n,
    input  logic start,
    input  logic abort,
    output logic ccff_head,
    output logic ccff_en,
    input  logic ccff_tail,
    output logic busy,
    output logic done,
    output logic aborted,
    ccff_bitstream_loader_if.slave bus
);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] LEN  = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [BW-1:0]        WW   = BW'(WORD_WIDTH);
    localparam logic [BW-1:0]        WMAX = BW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

    state_t                state, state_nx;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [BW-1:0]         bits_left;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] tail_sh;
    logic [BW-1:0]         tail_cnt;
    logic [WORD_WIDTH-1:0] tail_word_q;
    logic                  tail_valid_q;
    logic                  ready;

    logic                  in_load, take, shift, capture, last;
    logic [WORD_WIDTH-1:0] tail_next;
    logic [BW-1:0]         tail_shamt;

    assign bus.word_ready = ready;
    assign bus.tail_word  = tail_word_q;
    assign bus.tail_valid = tail_valid_q;

    // Per-cycle qualifiers; abort suppresses every datapath action in LOAD
    always_comb begin
        in_load    = (state == LOAD);
        take       = in_load && !abort && bus.word_valid && ready;
        shift      = in_load && !abort && (bits_left != '0) && (bit_cnt < LEN);
        capture    = in_load && !abort && ccff_en;
        last       = capture && (bit_cnt == LEN);
        tail_next  = {tail_sh[WORD_WIDTH-2:0], ccff_tail};
        tail_shamt = WMAX - tail_cnt;
    end

    // State register
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) state <= IDLE;
        else               state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (abort) state_nx = IDLE;
                     else if (last) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs; ready only when the current word is fully drained
    always_comb begin
        busy  = (state == LOAD);
        done  = (state == FIN);
        ready = (state == LOAD) && (bits_left == '0) && (bit_cnt < LEN);
    end

    // Serializer, bit counter and readback capture
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            bit_cnt      <= '0;
            bits_left    <= '0;
            shreg        <= '0;
            tail_sh      <= '0;
            tail_cnt     <= '0;
            tail_word_q  <= '0;
            tail_valid_q <= 1'b0;
            ccff_head    <= 1'b0;
            ccff_en      <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            ccff_en      <= shift;
            aborted      <= in_load && abort;
            tail_valid_q <= 1'b0;
            if (state == IDLE && start) begin
                bit_cnt   <= '0;
                bits_left <= '0;
                tail_sh   <= '0;
                tail_cnt  <= '0;
            end
            if (take) begin
                shreg     <= bus.word_in;
                bits_left <= WW;
            end
            if (shift) begin
                ccff_head <= shreg[WORD_WIDTH-1];
                shreg     <= shreg << 1;
                bits_left <= bits_left - BW'(1);
                bit_cnt   <= bit_cnt + CNT_WIDTH'(1);
            end
            // A full group, or the final partial group left-aligned, emits a word
            if (capture) begin
                if (last || tail_cnt == WMAX) begin
                    tail_word_q  <= tail_next << tail_shamt;
                    tail_valid_q <= 1'b1;
                    tail_sh      <= '0;
                    tail_cnt     <= '0;
                end else begin
                    tail_sh  <= tail_next;
                    tail_cnt <= tail_cnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (4-bit and 20-bit chains)
// with a behavioural chain model and an expected-stream scoreboard.
module tb_ccff_bitstream_loader;
    logic       prog_clk = 1'b0;
    logic       prog_reset_n = 1'b0;
    logic       start[2], abort[2], wvalid[2], wready[2];
    logic [7:0] win[2], tword[2];
    logic       head[2], en[2], tail[2], busy[2], done[2], aborted[2], tvalid[2];

    logic [31:0] chain[2];
    logic        pre_en[2];
    logic [31:0] pre_val[2];

    // Expected head-bit stream and readback-word stream per instance
    logic       exp_bits[2][128];
    logic [7:0] exp_tw[2][32];
    int wr[2] = '{0, 0}, rd[2] = '{0, 0}, base[2] = '{0, 0};
    int twr[2] = '{0, 0}, trd[2] = '{0, 0}, tbase[2] = '{0, 0};

    int en_total[2] = '{0, 0}, gap_total[2] = '{0, 0}, low_run[2] = '{0, 0};
    int tv_total[2] = '{0, 0}, done_total[2] = '{0, 0}, ab_total[2] = '{0, 0};
    int hs_total[2] = '{0, 0};
    logic seen[2] = '{1'b0, 1'b0}, fin_pend[2] = '{1'b0, 1'b0}, prev_head[2] = '{1'b0, 1'b0};
    logic dexp;

    int tests = 0, fails = 0;

    always #5 prog_clk = ~prog_clk;

    for (genvar g = 0; g < 2; g++) begin : gen
        localparam int L = (g == 0) ? 4 : 20;
        ccff_bitstream_loader_if #(.WORD_WIDTH(8)) ifc ();
        assign ifc.word_in    = win[g];
        assign ifc.word_valid = wvalid[g];
        assign wready[g]      = ifc.word_ready;
        assign tword[g]       = ifc.tail_word;
        assign tvalid[g]      = ifc.tail_valid;
        assign tail[g]        = chain[g][L-1];

        ccff_bitstream_loader #(.CHAIN_LENGTH(L), .WORD_WIDTH(8), .CNT_WIDTH(16)) dut (
            .prog_clk     (prog_clk),
            .prog_reset_n (prog_reset_n),
            .start        (start[g]),
            .abort        (abort[g]),
            .ccff_head    (head[g]),
            .ccff_en      (en[g]),
            .ccff_tail    (tail[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .aborted      (aborted[g]),
            .bus          (ifc)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Chain model: shifts in ccff_head on enabled edges; also counts handshakes
    always @(posedge prog_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pre_en[d])  chain[d] <= pre_val[d];
            else if (en[d]) chain[d] <= {chain[d][30:0], head[d]};
            if (prog_reset_n && wvalid[d] && wready[d] && !abort[d]) hs_total[d] <= hs_total[d] + 1;
        end
    end

    // Compare process: every cycle, outputs against the expected streams
    always @(negedge prog_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!prog_reset_n) begin
                fin_pend[d] = 1'b0; prev_head[d] = 1'b0; low_run[d] = 0; seen[d] = 1'b0;
            end else begin
                if (rd[d] < base[d])   rd[d]  = base[d];
                if (trd[d] < tbase[d]) trd[d] = tbase[d];
                dexp = fin_pend[d];
                fin_pend[d] = 1'b0;
                if (en[d]) begin
                    if (rd[d] >= wr[d]) chk($sformatf("extra_en%0d", d), en[d], 0);
                    else begin
                        chk($sformatf("head%0d[%0d]", d, rd[d]), head[d], exp_bits[d][rd[d]]);
                        rd[d]++;
                        if (rd[d] == wr[d]) fin_pend[d] = 1'b1;
                    end
                    en_total[d]++;
                    gap_total[d] += low_run[d];
                    low_run[d] = 0;
                    seen[d] = 1'b1;
                end else begin
                    chk($sformatf("head_hold%0d", d), head[d], prev_head[d]);
                    if (busy[d] && seen[d]) low_run[d]++;
                end
                if (!busy[d]) begin seen[d] = 1'b0; low_run[d] = 0; end
                chk($sformatf("done%0d", d), done[d], dexp);
                if (dexp) chk($sformatf("tail_with_done%0d", d), tvalid[d], 1);
                if (tvalid[d]) begin
                    if (trd[d] >= twr[d]) chk($sformatf("extra_tail%0d", d), tvalid[d], 0);
                    else begin
                        chk($sformatf("tail_word%0d", d), tword[d], exp_tw[d][trd[d]]);
                        trd[d]++;
                        tv_total[d]++;
                    end
                end
                if (done[d])    done_total[d]++;
                if (aborted[d]) ab_total[d]++;
                prev_head[d] = head[d];
            end
        end
    end

    // Expected streams for one load: first L bits of the words MSB-first,
    // and the current chain contents displaced tail-first, grouped by 8
    task automatic expect_load(input int d, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        int L, n;
        logic [23:0] s;
        logic [31:0] c;
        logic [7:0]  tw;
        L = (d == 0) ? 4 : 20;
        s = {w0, w1, w2};
        c = chain[d];
        for (int i = 0; i < L; i++) exp_bits[d][wr[d] + i] = s[23 - i];
        n = (L + 7) / 8;
        for (int k = 0; k < n; k++) begin
            tw = '0;
            for (int j = 0; j < 8; j++)
                if (8 * k + j < L) tw[7 - j] = c[L - 1 - (8 * k + j)];
            exp_tw[d][twr[d] + k] = tw;
        end
        twr[d] += n;
        wr[d]  += L;
    endtask

    task automatic pulse_start(input int d);
        @(negedge prog_clk); start[d] = 1'b1;
        @(negedge prog_clk); start[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [7:0] w, input int stall);
        int n = 0;
        while (!wready[d] && n < 200) begin @(negedge prog_clk); n++; end
        if (n >= 200) chk($sformatf("ready_timeout%0d", d), wready[d], 1);
        repeat (stall) @(negedge prog_clk);
        win[d] = w; wvalid[d] = 1'b1;
        @(posedge prog_clk); #1 wvalid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done[d] && n < 100) begin @(negedge prog_clk); n++; end
        chk($sformatf("done_seen%0d", d), done[d], 1);
        chk($sformatf("busy_at_done%0d", d), busy[d], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, gp, tv, hs, dn, ab;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; abort[d] = 0; wvalid[d] = 0; win[d] = '0;
        end
        pre_en[0] = 1'b1; pre_val[0] = 32'h6;       // chain 0110, tail first
        pre_en[1] = 1'b1; pre_val[1] = 32'hABCDE;
        @(posedge prog_clk); #1 pre_en[0] = 1'b0; pre_en[1] = 1'b0;
        @(negedge prog_clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_head%0d", d), head[d], 0);
            chk($sformatf("rst_en%0d", d), en[d], 0);
            chk($sformatf("rst_busy%0d", d), busy[d], 0);
            chk($sformatf("rst_done%0d", d), done[d], 0);
            chk($sformatf("rst_aborted%0d", d), aborted[d], 0);
            chk($sformatf("rst_ready%0d", d), wready[d], 0);
            chk($sformatf("rst_tvalid%0d", d), tvalid[d], 0);
            chk($sformatf("rst_tword%0d", d), tword[d], 0);
        end
        @(posedge prog_clk); #1 prog_reset_n = 1'b1;

        // word_valid in IDLE is not accepted
        win[0] = 8'hFF; wvalid[0] = 1'b1;
        repeat (3) begin
            @(negedge prog_clk);
            chk("idle_ready", wready[0], 0);
            chk("idle_en", en[0], 0);
        end
        wvalid[0] = 1'b0;
        chk("idle_no_hs", hs_total[0], 0);

        // Basic load: 0xA5 into a 4-bit chain preloaded 0110
        expect_load(0, 8'hA5, 8'h00, 8'h00);
        chk("model_tail_basic", exp_tw[0][twr[0] - 1], 8'h60);
        chk("model_bits_basic", {exp_bits[0][wr[0] - 4], exp_bits[0][wr[0] - 3],
                                 exp_bits[0][wr[0] - 2], exp_bits[0][wr[0] - 1]}, 4'hA);
        e = en_total[0]; gp = gap_total[0]; tv = tv_total[0]; hs = hs_total[0];
        pulse_start(0);
        chk("busy_basic", busy[0], 1);
        send(0, 8'hA5, 0);
        win[0] = 8'h77; wvalid[0] = 1'b1;     // offered but must never be taken
        wait_done(0);
        wvalid[0] = 1'b0;
        @(negedge prog_clk);
        chk("basic_en_count", en_total[0] - e, 4);
        chk("basic_gaps", gap_total[0] - gp, 0);
        chk("basic_tvalid", tv_total[0] - tv, 1);
        chk("basic_words", hs_total[0] - hs, 1);
        chk("basic_chain", chain[0][3:0], 4'hA);

        // Multi-word on the 20-bit chain, with a stray start mid-load
        expect_load(1, 8'hFF, 8'h00, 8'hC3);
        chk("model_tail_multi0", exp_tw[1][twr[1] - 3], 8'hAB);
        chk("model_tail_multi2", exp_tw[1][twr[1] - 1], 8'hE0);
        e = en_total[1]; gp = gap_total[1]; tv = tv_total[1]; hs = hs_total[1];
        pulse_start(1);
        send(1, 8'hFF, 0);
        pulse_start(1);
        send(1, 8'h00, 0);
        send(1, 8'hC3, 0);
        wait_done(1);
        @(negedge prog_clk);
        chk("multi_en_count", en_total[1] - e, 20);
        chk("multi_gaps", gap_total[1] - gp, 2);
        chk("multi_tvalid", tv_total[1] - tv, 3);
        chk("multi_words", hs_total[1] - hs, 3);
        chk("multi_chain", chain[1][19:0], 20'hFF00C);

        // Stall: second word withheld 5 cycles after ready
        expect_load(1, 8'h5A, 8'h3C, 8'h81);
        chk("model_tail_stall", exp_tw[1][twr[1] - 1], 8'hC0);
        e = en_total[1]; gp = gap_total[1];
        pulse_start(1);
        send(1, 8'h5A, 0);
        send(1, 8'h3C, 5);
        send(1, 8'h81, 0);
        wait_done(1);
        @(negedge prog_clk);
        chk("stall_en_count", en_total[1] - e, 20);
        chk("stall_gaps", gap_total[1] - gp, 7);
        chk("stall_chain", chain[1][19:0], 20'h5A3C8);

        // Abort after two bits
        dn = done_total[0]; ab = ab_total[0];
        expect_load(0, 8'hA5, 8'h00, 8'h00);
        pulse_start(0);
        send(0, 8'hA5, 0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        @(negedge prog_clk); abort[0] = 1'b1;
        @(negedge prog_clk); abort[0] = 1'b0;
        chk("abort_en", en[0], 0);
        chk("abort_pulse", aborted[0], 1);
        chk("abort_busy", busy[0], 0);
        base[0] = wr[0]; tbase[0] = twr[0];
        @(negedge prog_clk);
        chk("abort_pulse_end", aborted[0], 0);
        repeat (4) @(negedge prog_clk);
        chk("abort_no_done", done_total[0] - dn, 0);
        chk("abort_count", ab_total[0] - ab, 1);

        // start and abort together in IDLE: start wins, then abort in LOAD
        start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge prog_clk); start[0] = 1'b0;
        chk("start_wins_busy", busy[0], 1);
        @(negedge prog_clk); abort[0] = 1'b0;
        chk("start_wins_abort", aborted[0], 1);
        chk("start_wins_idle", busy[0], 0);

        // Reset mid-word, then a clean load
        expect_load(0, 8'hA5, 8'h00, 8'h00);
        pulse_start(0);
        send(0, 8'hA5, 0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        dn = done_total[0]; ab = ab_total[0];
        #2 prog_reset_n = 1'b0;
        #1;
        chk("mid_rst_head", head[0], 0);
        chk("mid_rst_en", en[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_tvalid", tvalid[0], 0);
        base[0] = wr[0]; tbase[0] = twr[0];
        @(negedge prog_clk);
        chk("mid_rst_done", done[0], 0);
        chk("mid_rst_aborted", aborted[0], 0);
        @(posedge prog_clk); #1 prog_reset_n = 1'b1;
        expect_load(0, 8'h3C, 8'h00, 8'h00);
        chk("model_tail_rst", exp_tw[0][twr[0] - 1], 8'hA0);
        e = en_total[0];
        pulse_start(0);
        send(0, 8'h3C, 0);
        wait_done(0);
        @(negedge prog_clk);
        chk("rst_load_en_count", en_total[0] - e, 4);
        chk("rst_load_chain", chain[0][3:0], 4'h3);
        chk("rst_done_count", done_total[0] - dn, 1);
        chk("rst_no_abort", ab_total[0] - ab, 0);

        repeat (3) @(negedge prog_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
